// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, single-byte holding register with
// valid/ready handoff, framing-error pulse and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 frame_good;
  logic                 rxs;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (rx),
    .q_o   (rxs)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    ovr_d      = ovr_q;
    frame_good = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            frame_good = 1'b1;
            state_d    = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        // A held break must end before a new start bit can be recognised.
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (valid_q && data_ready) valid_d = 1'b0;

    if (frame_good) begin
      if (!valid_q || data_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial stimulus with a byte scoreboard.
module tb_uart_rx;

  localparam int CPB = 434;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int tests;
  int fails;
  int ferr_seen;
  int vld_cycles;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         idle_bits;
  } frame_vec_t;

  frame_vec_t vecs[5];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  // Scoreboard: every accepted byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_err) ferr_seen++;
      if (data_valid) vld_cycles++;
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, data_out}, 32'hFFFF_FFFF);
        end else begin
          check("rx_byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    int f0;
    int v0;
    tests = 0;
    fails = 0;
    ferr_seen = 0;
    vld_cycles = 0;
    reset = 1'b0;
    rx = 1'b1;
    data_ready = 1'b0;

    vecs[0] = '{8'h00, 1'b1, 0};
    vecs[1] = '{8'hFF, 1'b1, 0};
    vecs[2] = '{8'hA5, 1'b1, 0};
    vecs[3] = '{8'h3C, 1'b0, 2};
    vecs[4] = '{8'h81, 1'b1, 1};

    tick(5);
    check("rst_data_out", {24'd0, data_out}, 32'h0);
    check("rst_data_valid", {31'd0, data_valid}, 32'h0);
    check("rst_frame_err", {31'd0, frame_err}, 32'h0);
    check("rst_overrun", {31'd0, overrun}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    reset = 1'b1;
    tick(CPB);

    // Single byte with the consumer always ready.
    data_ready = 1'b1;
    v0 = vld_cycles;
    f0 = ferr_seen;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    tick(CPB);
    check("b55_valid_cycles", vld_cycles - v0, 32'd1);
    check("b55_frame_err", ferr_seen - f0, 32'd0);
    check("b55_overrun", {31'd0, overrun}, 32'h0);
    check("b55_queue_empty", exp_q.size(), 32'd0);

    // Table of frames, back-to-back where idle_bits is zero.
    for (int i = 0; i < 5; i++) begin
      f0 = ferr_seen;
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      rx = 1'b1;
      tick(vecs[i].idle_bits * CPB + 4);
      check("vec_frame_err", ferr_seen - f0, {31'd0, ~vecs[i].stop});
    end
    tick(CPB);
    check("vec_queue_empty", exp_q.size(), 32'd0);
    check("vec_overrun", {31'd0, overrun}, 32'h0);

    // Two frames while the consumer is stalled: the second one is dropped.
    data_ready = 1'b0;
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    tick(CPB);
    check("ovr_flag", {31'd0, overrun}, 32'h1);
    check("ovr_held_valid", {31'd0, data_valid}, 32'h1);
    check("ovr_held_data", {24'd0, data_out}, 32'hA3);
    data_ready = 1'b1;
    tick(3);
    check("ovr_valid_cleared", {31'd0, data_valid}, 32'h0);
    check("ovr_data_kept", {24'd0, data_out}, 32'hA3);
    check("ovr_sticky", {31'd0, overrun}, 32'h1);
    check("ovr_queue_empty", exp_q.size(), 32'd0);
    reset = 1'b0;
    tick(2);
    check("ovr_cleared_by_reset", {31'd0, overrun}, 32'h0);
    reset = 1'b1;
    tick(CPB);

    // Bad stop bit followed by a held break.
    f0 = ferr_seen;
    v0 = vld_cycles;
    send_frame(8'h3C, 1'b0);
    tick(3 * CPB);
    check("brk_busy_low_line", {31'd0, busy}, 32'h1);
    check("brk_frame_err_once", ferr_seen - f0, 32'd1);
    rx = 1'b1;
    tick(10);
    check("brk_idle_after_high", {31'd0, busy}, 32'h0);
    tick(2 * CPB);
    check("brk_no_valid", vld_cycles - v0, 32'd0);
    check("brk_no_extra_err", ferr_seen - f0, 32'd1);

    // 2000 ns low glitch on an idle line.
    f0 = ferr_seen;
    v0 = vld_cycles;
    rx = 1'b0;
    tick(100);
    rx = 1'b1;
    tick(20);
    check("glitch_busy_in_start", {31'd0, busy}, 32'h1);
    tick(300);
    check("glitch_back_idle", {31'd0, busy}, 32'h0);
    check("glitch_no_valid", vld_cycles - v0, 32'd0);
    check("glitch_no_err", ferr_seen - f0, 32'd0);

    // Reset during bit 4 of a 0xFF frame, then a clean 0x81.
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(4 * CPB + 200);
    reset = 1'b0;
    tick(3);
    check("midrst_data_out", {24'd0, data_out}, 32'h0);
    check("midrst_data_valid", {31'd0, data_valid}, 32'h0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'h0);
    check("midrst_overrun", {31'd0, overrun}, 32'h0);
    check("midrst_busy", {31'd0, busy}, 32'h0);
    reset = 1'b1;
    tick(5 * CPB);
    check("midrst_idle_after", {31'd0, busy}, 32'h0);
    f0 = ferr_seen;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    tick(CPB);
    check("midrst_queue_empty", exp_q.size(), 32'd0);
    check("midrst_frame_err_none", ferr_seen - f0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
